// File: rtl/mem_stage.sv
// MEM stage of a 5-stage RV32I pipeline: data-memory req/ack transaction with byte-lane
// steering, load extension, writeback-value selection and the MEM/WB register.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RegWrite_i,
  input  logic [1:0]  ResultSrc_i,
  input  logic [3:0]  MemRead_i,
  input  logic [3:0]  MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  RD_addr_i,
  input  logic [31:0] pc_incr_i,
  input  logic [31:0] pc_target_i,
  input  logic        imm_ui_i,
  input  logic [31:0] imm_extd_i,
  output logic        RegWrite_o,
  output logic [31:0] Result_o,
  output logic [4:0]  RD_addr_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          err;
  logic [1:0]    addr_lo;
  logic [31:0]   load_data;

  logic        is_store, is_access, misaligned, access_go, timeout_hit;
  size_t       size;
  logic [3:0]  mask, be;
  logic [31:0] wdata_rep, ext, result_sel;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    is_store  = (MemWrite_i != 4'b0000);
    is_access = is_store || (MemRead_i != 4'b0000);
    size      = SZ_WORD;
    if (is_store) begin
      case (MemWrite_i)
        4'b0001: size = SZ_BYTE;
        4'b0011: size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end else begin
      case (MemRead_i[1:0])
        2'b01:   size = SZ_BYTE;
        2'b10:   size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end
    misaligned = is_access &&
                 (((size == SZ_HALF) && ALUResult_i[0]) ||
                  ((size == SZ_WORD) && (ALUResult_i[1:0] != 2'b00)));
    access_go  = is_access && !misaligned;

    mask      = 4'b1111;
    wdata_rep = WriteData_i;
    case (size)
      SZ_BYTE: begin mask = 4'b0001; wdata_rep = {4{WriteData_i[7:0]}};  end
      SZ_HALF: begin mask = 4'b0011; wdata_rep = {2{WriteData_i[15:0]}}; end
      default: begin mask = 4'b1111; wdata_rep = WriteData_i;            end
    endcase
    // Loads always fetch the whole word; the lane is picked out on ack.
    be = is_store ? (mask << ALUResult_i[1:0]) : 4'b1111;

    case (addr_lo)
      2'd0:    lane_b = dmem_rdata[7:0];
      2'd1:    lane_b = dmem_rdata[15:8];
      2'd2:    lane_b = dmem_rdata[23:16];
      default: lane_b = dmem_rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (MemRead_i[1:0])
      2'b01:   ext = MemRead_i[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b10:   ext = MemRead_i[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ext = dmem_rdata;
    endcase

    case (ResultSrc_i)
      2'b00:   result_sel = ALUResult_i;
      2'b01:   result_sel = load_data;
      2'b10:   result_sel = pc_incr_i;
      default: result_sel = imm_ui_i ? imm_extd_i : pc_target_i;
    endcase

    timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    stall_o     = ((state == S_IDLE) && access_go) || (state == S_WAIT);
    misalign_o  = (state == S_IDLE) && misaligned;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      err        <= 1'b0;
      addr_lo    <= 2'b00;
      load_data  <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0000;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      bus_err_o  <= 1'b0;
      RegWrite_o <= 1'b0;
      Result_o   <= '0;
      RD_addr_o  <= '0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        S_IDLE: if (access_go) begin
          state      <= S_WAIT;
          dmem_req   <= 1'b1;
          dmem_we    <= is_store;
          dmem_be    <= be;
          dmem_addr  <= {ALUResult_i[31:2], 2'b00};
          dmem_wdata <= is_store ? wdata_rep : '0;
          addr_lo    <= ALUResult_i[1:0];
          err        <= 1'b0;
          cnt        <= '0;
        end
        S_WAIT: if (dmem_ack) begin
          load_data <= ext;
          dmem_req  <= 1'b0;
          state     <= S_DONE;
        end else if (timeout_hit) begin
          dmem_req  <= 1'b0;
          bus_err_o <= 1'b1;
          err       <= 1'b1;
          state     <= S_DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase

      // MEM/WB register: bubble while stalled or on a dropped access.
      if (stall_o || misalign_o) begin
        RegWrite_o <= 1'b0;
      end else begin
        RegWrite_o <= RegWrite_i && !is_store && !((state == S_DONE) && err);
        Result_o   <= result_sel;
        RD_addr_o  <= RD_addr_i;
      end
    end
  end

endmodule
